// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter slice.
//
// Contents:
//   arb_state_t   : transaction sequencer states (IDLE, BUSY, ACK)
//   owner_t       : which requester currently owns the memory port
//   DEFAULT_*     : default address/data widths and timeout
//   counter_width : width of a counter that must be able to hold TIMEOUT
package mem_arb_pkg;

    localparam int DEFAULT_AW      = 32;
    localparam int DEFAULT_DW      = 32;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR,
        OWN_DATA
    } owner_t;

    // A disabled timeout (0) still gets a one-bit counter so that no
    // zero-width vectors appear anywhere.
    function automatic int counter_width(input int timeout);
        if (timeout < 1) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating cycle counter that flags a memory transaction that has waited
// too long for its response.
//
// Ports:
//   clk     : system clock
//   reset   : asynchronous, active-high reset
//   clear   : synchronous clear, wins over enable
//   enable  : count one cycle of waiting
//   expired : high during the last allowed waiting cycle, i.e. the cycle in
//             which the count is about to reach TIMEOUT; never asserted when
//             TIMEOUT is 0
module mem_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = counter_width(TIMEOUT);

    // The counter stops at TIMEOUT so that it can never wrap and re-fire.
    localparam logic [CW-1:0] SAT_VALUE = CW'(TIMEOUT);

    // Expiry is flagged one count early: the cycle holding TIMEOUT-1 is the
    // TIMEOUT-th waiting cycle, so the owner gets exactly TIMEOUT cycles.
    localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] count;

    // Counter register: cleared whenever no transaction is waiting, then
    // advances once per waiting cycle until it saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != SAT_VALUE)) begin
            count <= count + 1'b1;
        end
    end

    // A zero TIMEOUT turns the comparison off entirely.
    assign expired = (TIMEOUT != 0) && enable && (count >= LAST_WAIT);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one external memory port between the instruction-fetch and the
// data-memory requesters. One transaction runs at a time; the winner gets
// its read data and a one-cycle ack, and a hung memory is cut off by a
// timeout that finishes the transaction with err.
//
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   i_req/i_addr               : instruction read request (held until i_ack)
//   i_rdata/i_ack              : instruction read data and completion pulse
//   d_req/d_we/d_addr/d_wdata  : data request (held until d_ack)
//   d_rdata/d_ack              : data read data and completion pulse
//   err                        : pulses with the ack of a timed-out access
//   mem_addr/mem_wdata         : memory address and write data
//   mem_rden/mem_wren          : memory strobes, held until mem_response
//   mem_read_val/mem_response  : memory read data and completion
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rden,
    output logic          mem_wren,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_read_val,
    input  logic          mem_response
);

    arb_state_t state;
    arb_state_t state_next;
    owner_t     owner;
    owner_t     last_grant;
    owner_t     grant_side;
    logic       any_req;
    logic       op_we;
    logic       timed_out;
    logic       expired;

    // The counter only runs while a transaction waits in BUSY; leaving BUSY
    // clears it, so every grant starts from zero.
    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != BUSY),
        .enable  (state == BUSY),
        .expired (expired)
    );

    // Round-robin choice: a lone request wins outright, and on a tie the
    // side that did not win last time goes first. last_grant resets to the
    // instruction side so data wins the very first tie.
    always_comb begin
        any_req    = i_req | d_req;
        grant_side = OWN_INSTR;
        if (d_req && (!i_req || (last_grant == OWN_INSTR))) begin
            grant_side = OWN_DATA;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. ACK always falls back to IDLE without looking at the
    // requests, which forces a one-cycle bubble between transactions and
    // lets the finished requester drop its request in time.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_response || expired) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transaction datapath. The request is captured only at the grant, so
    // requester inputs can change freely while BUSY. A response beats a
    // timeout arriving in the same cycle, and a write never touches the
    // read-data registers. Responses outside BUSY are stray and ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_INSTR;
            last_grant <= OWN_INSTR;
            op_we      <= 1'b0;
            timed_out  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= grant_side;
                        last_grant <= grant_side;
                        timed_out  <= 1'b0;
                        if (grant_side == OWN_DATA) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            op_we     <= d_we;
                        end else begin
                            mem_addr  <= i_addr;
                            op_we     <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_response) begin
                        timed_out <= 1'b0;
                        if (!op_we) begin
                            if (owner == OWN_DATA) begin
                                d_rdata <= mem_read_val;
                            end else begin
                                i_rdata <= mem_read_val;
                            end
                        end
                    end else if (expired) begin
                        timed_out <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the state. Because they follow the asynchronously
    // reset state register, strobes, acks and err drop the moment reset
    // rises, abandoning any transaction in flight.
    always_comb begin
        mem_rden = (state == BUSY) && !op_we;
        mem_wren = (state == BUSY) && op_we;
        i_ack    = (state == ACK) && (owner == OWN_INSTR);
        d_ack    = (state == ACK) && (owner == OWN_DATA);
        err      = (state == ACK) && timed_out;
    end

endmodule
